amp_i2c_master: RTL and testbench
=================================

Name: amp_i2c_master

Overview:
- Byte-oriented I2C master driving the amplifier control bus (amp_i2c_scl / amp_i2c_sdai / amp_i2c_sdao / amp_i2c_sdaoe).
- It is the initiator counterpart to the slave-side i2c_if register interface.
- It executes one single-register write or single-register read per request.
- Requests come from register-bank fields or a sequencer in toi2s_tt_top.

Parameters:
- CLK_DIV, 16, clk cycles per quarter SCL bit period; minimum 4. SCL frequency = clk / (4*CLK_DIV).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; accepted only while busy=0
- rw  input  1  0 = write, 1 = read; latched at accept
- dev_addr  input  7  7-bit slave address; latched at accept
- reg_addr  input  8  register index; latched at accept
- wr_data  input  8  write byte; latched at accept
- rd_data  output  8  byte returned by the last successful read
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at end of transaction
- ack_err  output  1  last transaction saw a NACK; valid with done, held until next accept
- scl  output  1  SCL, push-pull
- sdai  input  1  SDA input from pad
- sdao  output  1  SDA output value; always 0 (open-drain)
- sdaoe  output  1  1 = pull SDA low; 0 = release SDA

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, on the port reset.
- Reset values: scl=1, sdaoe=0, sdao=0, busy=0, done=0, ack_err=0, rd_data=0x00, FSM=IDLE, quarter counter=0.
- Reset asserted mid-transaction: all of the above apply on the next clk edge. The bus is released without a STOP; this is accepted behaviour.
- sdai passes through a 2-flop synchronizer before use.
- Tick: the quarter counter counts 0..CLK_DIV-1. Each quarter lasts CLK_DIV cycles.
- Accept: in IDLE with start=1, latch the inputs, clear ack_err, and set busy=1 on the next cycle. start while busy is ignored.
- FSM states: IDLE, START, ADDR_W, REG, WDATA, RSTART, ADDR_R, RDATA, STOP.
- Write sequence: START -> ADDR_W -> REG -> WDATA -> STOP.
- Read sequence: START -> ADDR_W -> REG -> RSTART -> ADDR_R -> RDATA -> STOP.
- START / RSTART (4 quarters):
  - q0: scl=0, SDA released.
  - q1: scl=1.
  - q2: scl=1, sdaoe=1.
  - q3: scl=0, SDA held low.
- Byte states: 9 bits each, 4 quarters per bit.
  - q0: scl=0, set SDA (bit 0 -> sdaoe=1, bit 1 -> sdaoe=0).
  - q1 and q2: scl=1.
  - Sample synchronized sdai on the last cycle of q2.
  - q3: scl=0.
  - Bits 1-8 are data, MSB first. ADDR_W sends {dev_addr,0}; ADDR_R sends {dev_addr,1}.
  - Bit 9 is the ACK slot. When transmitting, SDA is released and sdai=1 means NACK.
  - In RDATA, SDA is released for bits 1-8 and the samples shift into a register. Bit 9: master sends NACK (SDA released).
- NACK handling: any slave NACK sets ack_err=1 and moves directly to STOP. The remaining bytes are skipped and rd_data is not updated.
- STOP (4 quarters):
  - q0: scl=0, sdaoe=1.
  - q1: scl=1, sdaoe=1.
  - q2: scl=1, sdaoe=0.
  - q3: idle levels.
- End of STOP q3: done=1 for one cycle, and busy=0 in the same cycle. For a successful read, rd_data updates in that same cycle.
- Next accept is possible on the cycle after done.
- Duration from the first START quarter to done:
  - Write: 116 quarters.
  - Read: 156 quarters.
  - NACK on the address byte: 44 quarters.
- SCL never changes in the same quarter as SDA, except at the START/STOP edges defined above.
- No clock stretching and no arbitration. sdai is ignored outside the ACK slots and RDATA.

Test Plan:
- Write with CLK_DIV=4, dev_addr=0x2C, reg_addr=0x05, wr_data=0xA7, slave model ACKs all bytes -> SDA bytes 0x58, 0x05, 0xA7; done after 464 cycles; ack_err=0; SCL period 16 clk.
- Read with dev_addr=0x2C, reg_addr=0x10, slave returns 0x3C -> bytes 0x58, 0x10, repeated START, 0x59; master NACKs the data byte; rd_data=0x3C; done after 624 cycles.
- Absent device (sdai held 1) -> STOP follows the first ACK slot; ack_err=1; done after 176 cycles; rd_data unchanged.
- Slave NACKs the register byte -> STOP immediately after; ack_err=1; WDATA never sent.
- start pulsed during busy with different inputs -> ignored; the bus trace matches the original request. A back-to-back start on the cycle after done is accepted.
- reset asserted during REG bit 4 -> next cycle scl=1, sdaoe=0, busy=0, done never pulses; a subsequent write completes correctly.

Source files
------------

// File: rtl/amp_i2c_master.sv
// Byte-oriented I2C master for the amplifier control bus: one single-register
// write or read per accepted request, SDA driven open-drain through sdaoe.
module amp_i2c_master #(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       scl,
   input  logic       sdai,
   output logic       sdao,
   output logic       sdaoe
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_START  = 4'd1,
      S_ADDR_W = 4'd2,
      S_REG    = 4'd3,
      S_WDATA  = 4'd4,
      S_RSTART = 4'd5,
      S_ADDR_R = 4'd6,
      S_RDATA  = 4'd7,
      S_STOP   = 4'd8
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      qtr_q, qtr_d;
   logic [3:0]      bit_q, bit_d;
   logic            rw_q, rw_d;
   logic [6:0]      dev_q, dev_d;
   logic [7:0]      reg_q, reg_d;
   logic [7:0]      wdat_q, wdat_d;
   logic [7:0]      rx_q, rx_d;
   logic            samp_q, samp_d;
   logic [7:0]      rd_data_q, rd_data_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ack_err_q, ack_err_d;
   logic            scl_q, scl_d;
   logic            sdaoe_q, sdaoe_d;
   logic            sync1_q, sync2_q;
   logic [7:0]      tx_byte;
   logic            tick;

   // Bus levels {scl, sdaoe} for a given state, quarter and bit position.
   function automatic logic [1:0] bus_levels(input state_t st, input logic [1:0] qtr,
                                             input logic [3:0] bitn, input logic [7:0] tx);
      logic [1:0] lv;
      logic       scl_hi;
      scl_hi = qtr[0] ^ qtr[1];
      case (st)
         S_IDLE: lv = 2'b10;
         S_START, S_RSTART: begin
            case (qtr)
               2'd0:    lv = 2'b00;
               2'd1:    lv = 2'b10;
               2'd2:    lv = 2'b11;
               default: lv = 2'b01;
            endcase
         end
         S_STOP: begin
            case (qtr)
               2'd0:    lv = 2'b01;
               2'd1:    lv = 2'b11;
               default: lv = 2'b10;
            endcase
         end
         S_RDATA: lv = {scl_hi, 1'b0};
         default: lv = {scl_hi, (bitn < 4'd8) ? ~tx[3'd7 - bitn[2:0]] : 1'b0};
      endcase
      return lv;
   endfunction

   assign tick    = (cnt_q == CNT_LAST);
   assign rd_data = rd_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ack_err = ack_err_q;
   assign scl     = scl_q;
   assign sdaoe   = sdaoe_q;
   assign sdao    = 1'b0;

   // SDA input synchronizer.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= sdai;
         sync2_q <= sync1_q;
      end
   end

   // Sequencer next-state, sampling and output-level computation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      qtr_d     = qtr_q;
      bit_d     = bit_q;
      rw_d      = rw_q;
      dev_d     = dev_q;
      reg_d     = reg_q;
      wdat_d    = wdat_q;
      rx_d      = rx_q;
      samp_d    = samp_q;
      rd_data_d = rd_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ack_err_d = ack_err_q;
      tx_byte   = 8'h00;

      if (state_q == S_IDLE) begin
         cnt_d = {CW{1'b0}};
         qtr_d = 2'd0;
         bit_d = 4'd0;
         if (start) begin
            rw_d      = rw;
            dev_d     = dev_addr;
            reg_d     = reg_addr;
            wdat_d    = wr_data;
            ack_err_d = 1'b0;
            busy_d    = 1'b1;
            state_d   = S_START;
         end else begin
            busy_d = 1'b0;
         end
      end else begin
         cnt_d = tick ? {CW{1'b0}} : cnt_q + CNT_ONE;
         qtr_d = tick ? qtr_q + 2'd1 : qtr_q;

         // Sample on the last cycle of q2: data bits in RDATA, ACK slot elsewhere.
         if (tick && qtr_q == 2'd2) begin
            if (state_q == S_RDATA && bit_q != 4'd8) begin
               rx_d = {rx_q[6:0], sync2_q};
            end else if (bit_q == 4'd8) begin
               samp_d = sync2_q;
            end else begin
               samp_d = samp_q;
            end
         end else begin
            samp_d = samp_q;
         end

         if (tick && qtr_q == 2'd3) begin
            case (state_q)
               S_START:  state_d = S_ADDR_W;
               S_RSTART: state_d = S_ADDR_R;
               S_STOP: begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  if (rw_q && !ack_err_q) begin
                     rd_data_d = rx_q;
                  end else begin
                     rd_data_d = rd_data_q;
                  end
               end
               default: begin
                  if (bit_q != 4'd8) begin
                     bit_d = bit_q + 4'd1;
                  end else begin
                     bit_d = 4'd0;
                     if (samp_q && state_q != S_RDATA) begin
                        ack_err_d = 1'b1;
                        state_d   = S_STOP;
                     end else begin
                        case (state_q)
                           S_ADDR_W: state_d = S_REG;
                           S_REG:    state_d = rw_q ? S_RSTART : S_WDATA;
                           S_ADDR_R: state_d = S_RDATA;
                           default:  state_d = S_STOP;
                        endcase
                     end
                  end
               end
            endcase
         end else begin
            state_d = state_q;
         end
      end

      case (state_d)
         S_ADDR_W: tx_byte = {dev_q, 1'b0};
         S_REG:    tx_byte = reg_q;
         S_WDATA:  tx_byte = wdat_q;
         S_ADDR_R: tx_byte = {dev_q, 1'b1};
         default:  tx_byte = 8'h00;
      endcase

      // Output levels follow the next state so scl/sdaoe stay aligned with it.
      {scl_d, sdaoe_d} = bus_levels(state_d, qtr_d, bit_d, tx_byte);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= {CW{1'b0}};
         qtr_q     <= 2'd0;
         bit_q     <= 4'd0;
         rw_q      <= 1'b0;
         dev_q     <= 7'h00;
         reg_q     <= 8'h00;
         wdat_q    <= 8'h00;
         rx_q      <= 8'h00;
         samp_q    <= 1'b0;
         rd_data_q <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         scl_q     <= 1'b1;
         sdaoe_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         qtr_q     <= qtr_d;
         bit_q     <= bit_d;
         rw_q      <= rw_d;
         dev_q     <= dev_d;
         reg_q     <= reg_d;
         wdat_q    <= wdat_d;
         rx_q      <= rx_d;
         samp_q    <= samp_d;
         rd_data_q <= rd_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         scl_q     <= scl_d;
         sdaoe_q   <= sdaoe_d;
      end
   end

endmodule

// File: tb/tb_amp_i2c_master.sv
// Bench for amp_i2c_master: a bus-level slave model decodes START/STOP/bytes
// and checks them, plus done results, against a transaction-level reference.
module tb_amp_i2c_master;

   localparam int DIV = 4;
   localparam int TOK_S = 1000;
   localparam int TOK_P = 1001;

   logic       clk = 1'b0;
   logic       reset, start, rw;
   logic [6:0] dev_addr;
   logic [7:0] reg_addr, wr_data;
   logic [7:0] rd_data;
   logic       busy, done, ack_err, scl, sdao, sdaoe, sdai;
   logic       slave_low = 1'b0;
   logic       bus_sda;

   assign bus_sda = ~sdaoe & ~slave_low;
   assign sdai    = bus_sda;

   always #5 clk = ~clk;

   amp_i2c_master #(.CLK_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .start(start), .rw(rw),
      .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
      .rd_data(rd_data), .busy(busy), .done(done), .ack_err(ack_err),
      .scl(scl), .sdai(sdai), .sdao(sdao), .sdaoe(sdaoe)
   );

   typedef struct packed {
      logic        err;
      logic [7:0]  rd;
      logic [31:0] ncyc;
   } done_t;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         exp_tok[$];
   done_t      exp_done[$];
   logic [7:0] model_rd = 8'h00;
   bit         trace_en = 1'b0;
   bit         ack_cfg[3];
   logic [7:0] rd_val = 8'h00;

   // slave model state
   int         s_bits = 0, s_midx = 0, last_rise = 0;
   logic [7:0] s_shift = 8'h00;
   bit         s_tx = 1'b0, s_first = 1'b0;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_tok(input int got);
      int e;
      if (exp_tok.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL bus_token: got %0d expected none", got);
      end else begin
         e = exp_tok.pop_front();
         check("bus_token", got, e);
      end
   endtask

   // Slave: START/STOP detection, bit shifting, ACK and read-data driving.
   always @(scl or bus_sda) begin
      bit nxt;
      if (!trace_en) begin
         s_bits = 0; s_midx = 0; s_tx = 1'b0; slave_low = 1'b0;
      end else if (scl === 1'b1 && prev_scl === 1'b1 && bus_sda !== prev_sda) begin
         if (bus_sda === 1'b0) begin
            check_tok(TOK_S);
            s_first = 1'b1;
         end else begin
            check_tok(TOK_P);
            s_midx = 0;
         end
         s_bits = 0;
         s_tx = 1'b0;
      end else if (scl === 1'b1 && prev_scl !== 1'b1) begin
         if (s_bits >= 1 && s_bits <= 8) check("scl_period", cyc - last_rise, 4 * DIV);
         last_rise = cyc;
         if (s_bits < 8) begin
            s_shift = {s_shift[6:0], bus_sda};
            s_bits++;
         end else begin
            check_tok((bus_sda === 1'b1 ? 256 : 0) + int'(s_shift));
            nxt = s_first && s_shift[0] && (bus_sda === 1'b0) && !s_tx;
            if (!s_tx) s_midx++;
            s_tx = nxt;
            s_first = 1'b0;
            s_bits = 0;
         end
      end else if (scl === 1'b0 && prev_scl === 1'b1) begin
         if (s_bits == 8 && !s_tx) slave_low = (s_midx < 3) ? ack_cfg[s_midx] : 1'b0;
         else if (s_tx && s_bits < 8) slave_low = ~rd_val[7 - s_bits];
         else slave_low = 1'b0;
      end
      prev_scl = scl;
      prev_sda = bus_sda;
   end

   // Done monitor: pops the expected transaction result.
   logic prev_busy = 1'b0, prev_done = 1'b0;
   int   t_busy = 0;
   always @(negedge clk) begin
      done_t e;
      cyc++;
      if (busy === 1'b1 && prev_busy !== 1'b1) t_busy = cyc;
      if (done === 1'b1) begin
         if (exp_done.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected: got 1 expected 0");
         end else begin
            e = exp_done.pop_front();
            check("ack_err", ack_err, e.err);
            check("rd_data", rd_data, e.rd);
            check("duration", cyc - t_busy, e.ncyc);
            check("busy_at_done", busy, 0);
            check("trace_left", exp_tok.size(), 0);
         end
         check("done_pulse", prev_done, 0);
      end
      prev_busy = busy;
      prev_done = done;
   end

   // Issue a request and push its expected bus trace and result.
   task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd,
                        input bit a0, input bit a1, input bit a2, input logic [7:0] rv);
      int    nb, nrs;
      logic  err;
      done_t e;
      ack_cfg[0] = a0; ack_cfg[1] = a1; ack_cfg[2] = a2;
      rd_val = rv;
      nb = 1; nrs = 0; err = !a0;
      exp_tok.push_back(TOK_S);
      exp_tok.push_back((a0 ? 0 : 256) + int'({d, 1'b0}));
      if (a0) begin
         exp_tok.push_back((a1 ? 0 : 256) + int'(ra));
         nb = 2; err = !a1;
         if (a1) begin
            nb = 3; err = !a2;
            if (!r) begin
               exp_tok.push_back((a2 ? 0 : 256) + int'(wd));
            end else begin
               exp_tok.push_back(TOK_S);
               nrs = 1;
               exp_tok.push_back((a2 ? 0 : 256) + int'({d, 1'b1}));
               if (a2) begin
                  exp_tok.push_back(256 + int'(rv));
                  nb = 4;
                  model_rd = rv;
               end
            end
         end
      end
      exp_tok.push_back(TOK_P);
      e.err = err;
      e.rd = model_rd;
      e.ncyc = 32'((8 + 4 * nrs + 36 * nb) * DIV);
      exp_done.push_back(e);
      start = 1'b1; rw = r; dev_addr = d; reg_addr = ra; wr_data = wd;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL timeout_%s: got no done expected done", name);
         exp_tok.delete();
         exp_done.delete();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [31:0] rnd;
      int          n;
      reset = 1'b1; start = 1'b0; rw = 1'b0;
      dev_addr = 7'h00; reg_addr = 8'h00; wr_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_scl", scl, 1); check("rst_sdaoe", sdaoe, 0); check("rst_sdao", sdao, 0);
      check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_ack_err", ack_err, 0);
      check("rst_rd_data", rd_data, 0);
      reset = 1'b0;
      @(negedge clk);
      trace_en = 1'b1;
      @(negedge clk);

      issue(1'b0, 7'h2C, 8'h05, 8'hA7, 1'b1, 1'b1, 1'b1, 8'h00); wait_done("write");
      repeat (3) @(negedge clk);
      issue(1'b1, 7'h2C, 8'h10, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C); wait_done("read");
      repeat (3) @(negedge clk);
      issue(1'b1, 7'h2C, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC3); wait_done("absent");
      repeat (3) @(negedge clk);
      issue(1'b0, 7'h2C, 8'h06, 8'h11, 1'b1, 1'b0, 1'b1, 8'h00); wait_done("reg_nack");
      repeat (3) @(negedge clk);

      // start pulses while busy must be ignored; then a back-to-back request
      issue(1'b0, 7'h2C, 8'h33, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h00);
      repeat (60) @(negedge clk);
      start = 1'b1; rw = 1'b1; dev_addr = 7'h11; reg_addr = 8'hEE; wr_data = 8'h00;
      @(negedge clk);
      start = 1'b0;
      repeat (200) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start");
      @(negedge clk);
      issue(1'b1, 7'h4D, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 8'h96); wait_done("back_to_back");
      repeat (3) @(negedge clk);

      // reset in the middle of the register byte
      issue(1'b0, 7'h2C, 8'h21, 8'h99, 1'b1, 1'b1, 1'b1, 8'h00);
      n = 0;
      while (!(s_midx == 1 && s_bits == 4) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reach_reg_bit4", (s_midx == 1 && s_bits == 4) ? 1 : 0, 1);
      trace_en = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_scl", scl, 1); check("mid_rst_sdaoe", sdaoe, 0);
      check("mid_rst_busy", busy, 0); check("mid_rst_done", done, 0);
      check("mid_rst_rd_data", rd_data, 0);
      reset = 1'b0;
      exp_tok.delete();
      exp_done.delete();
      model_rd = 8'h00;
      repeat (600) @(negedge clk);
      trace_en = 1'b1;
      @(negedge clk);
      issue(1'b0, 7'h2C, 8'h21, 8'h99, 1'b1, 1'b1, 1'b1, 8'h00); wait_done("after_reset");
      repeat (3) @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         rnd = $urandom;
         issue(rnd[0], rnd[7:1], rnd[15:8], rnd[23:16],
               $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
               $urandom_range(0, 5) != 0, rnd[31:24]);
         wait_done("random");
         repeat (2) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
